// File: rtl/jk_bank_driver.sv
// Drives the J/K inputs of an external JK flip-flop bank. It drives for one cycle,
// checks the Q feedback, and retries up to MAX_RETRY times on mismatch.
module jk_bank_driver #(
  parameter int WIDTH         = 4,
  parameter int MAX_RETRY     = 2,
  parameter int TOGGLE_POLICY = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       retry_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);

  state_t           state_reg;
  logic [WIDTH-1:0] target_reg;
  logic [7:0]       retry_used_reg;
  logic [WIDTH-1:0] exc_target;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             mismatch;

  // In IDLE the excitation is computed from the word being accepted,
  // otherwise from the latched target (retry path).
  assign exc_target = (state_reg == IDLE) ? in_target : target_reg;
  assign mismatch   = (q_fb != target_reg);
  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_exc
      logic diff;
      assign diff = exc_target[gi] ^ q_fb[gi];
      if (TOGGLE_POLICY == 0) begin : g_setclr
        assign exc_j[gi] = diff & exc_target[gi];
        assign exc_k[gi] = diff & ~exc_target[gi];
      end else begin : g_toggle
        assign exc_j[gi] = diff;
        assign exc_k[gi] = diff;
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      target_reg     <= '0;
      retry_used_reg <= '0;
      retry_cnt      <= '0;
      j_out          <= '0;
      k_out          <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          j_out <= '0;
          k_out <= '0;
          if (in_valid) begin
            target_reg     <= in_target;
            retry_used_reg <= '0;
            retry_cnt      <= '0;
            j_out          <= exc_j;
            k_out          <= exc_k;
            state_reg      <= DRIVE;
          end
        end
        DRIVE: begin
          j_out     <= '0;
          k_out     <= '0;
          state_reg <= CHECK;
        end
        CHECK: begin
          j_out <= '0;
          k_out <= '0;
          if (!mismatch) begin
            done      <= 1'b1;
            state_reg <= IDLE;
          end else if (retry_used_reg < MAX_RETRY_W) begin
            retry_used_reg <= retry_used_reg + 8'd1;
            // The visible count saturates; the internal one keeps counting.
            retry_cnt      <= (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
            j_out          <= exc_j;
            k_out          <= exc_k;
            state_reg      <= DRIVE;
          end else begin
            err       <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          j_out     <= '0;
          k_out     <= '0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (set/clear and toggle policy) each
// driving a behavioural JK bank, with a queue of expected transaction results.
module tb_jk_bank_driver;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] in_target;

  logic       valid0, ready0, busy0, done0, err0;
  logic [3:0] j0, k0, q_fb0, bank0, bank0_val, stuck0;
  logic [1:0] rc0;
  logic       bank0_load;

  logic       valid1, ready1, busy1, done1, err1;
  logic [3:0] j1, k1, bank1, bank1_val;
  logic [1:0] rc1;
  logic       bank1_load;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       is_err;
    logic [1:0] retry;
    logic [3:0] bank;
    int         lat;
    int         drives;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2), .TOGGLE_POLICY(0)) u0 (
    .CLK(CLK), .RESET(RESET), .in_valid(valid0), .in_ready(ready0),
    .in_target(in_target), .q_fb(q_fb0), .j_out(j0), .k_out(k0),
    .busy(busy0), .done(done0), .err(err0), .retry_cnt(rc0)
  );

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2), .TOGGLE_POLICY(1)) u1 (
    .CLK(CLK), .RESET(RESET), .in_valid(valid1), .in_ready(ready1),
    .in_target(in_target), .q_fb(bank1), .j_out(j1), .k_out(k1),
    .busy(busy1), .done(done1), .err(err1), .retry_cnt(rc1)
  );

  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({j[i], k[i]})
        2'b00: r[i] = q[i];
        2'b10: r[i] = 1'b1;
        2'b01: r[i] = 1'b0;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  // Behavioural JK banks; stuck0 models a stuck-at-0 fault on the feedback only.
  always @(posedge CLK) begin
    bank0 <= bank0_load ? bank0_val : jk_next(bank0, j0, k0);
    bank1 <= bank1_load ? bank1_val : jk_next(bank1, j1, k1);
  end
  assign q_fb0 = bank0 & ~stuck0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_bank(input int sel, input logic [3:0] v);
    if (sel == 0) begin bank0_val = v; bank0_load = 1'b1; end
    else          begin bank1_val = v; bank1_load = 1'b1; end
    step();
    bank0_load = 1'b0;
    bank1_load = 1'b0;
  endtask

  // Offer a target, take the accept edge, and leave the DUT in DRIVE.
  task automatic accept(input int sel, input logic [3:0] t);
    in_target = t;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    step();
    valid0 = 1'b0;
    valid1 = 1'b0;
  endtask

  // Counts edges until done|err (cyc = -1 on timeout) and cycles with J/K active.
  task automatic wait_out(input int sel, output int cyc, output int drives);
    logic [3:0] jj, kk;
    jj = (sel == 0) ? j0 : j1;
    kk = (sel == 0) ? k0 : k1;
    drives = ((jj | kk) != 4'b0) ? 1 : 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      jj = (sel == 0) ? j0 : j1;
      kk = (sel == 0) ? k0 : k1;
      if ((jj | kk) != 4'b0) drives++;
      if ((sel == 0) ? (done0 | err0) : (done1 | err1)) begin
        cyc = c;
        return;
      end
    end
    cyc = -1;
  endtask

  task automatic check_result(input string name, input int sel, input int cyc, input int drives);
    exp_t e;
    logic got_err, got_done;
    logic [1:0] got_rc;
    logic [3:0] got_bank;
    e        = sb.pop_front();
    got_err  = (sel == 0) ? err0 : err1;
    got_done = (sel == 0) ? done0 : done1;
    got_rc   = (sel == 0) ? rc0 : rc1;
    got_bank = (sel == 0) ? bank0 : bank1;
    n_total++;
    if (cyc !== e.lat) $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
    else n_pass++;
    n_total++;
    if (got_err !== e.is_err || got_done !== !e.is_err)
      $display("FAIL %s done/err: got done=%b err=%b want err=%b", name, got_done, got_err, e.is_err);
    else n_pass++;
    n_total++;
    if (got_rc !== e.retry) $display("FAIL %s retry_cnt: got %0d want %0d", name, got_rc, e.retry);
    else n_pass++;
    n_total++;
    if (got_bank !== e.bank) $display("FAIL %s bank: got %b want %b", name, got_bank, e.bank);
    else n_pass++;
    n_total++;
    if (drives !== e.drives) $display("FAIL %s drive cycles: got %0d want %0d", name, drives, e.drives);
    else n_pass++;
    $display("txn %s: lat=%0d drives=%0d done=%b err=%b retry=%0d bank=%b",
             name, cyc, drives, got_done, got_err, got_rc, got_bank);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    n_total++;
    if ({ready0, busy0, done0, err0, rc0, j0, k0} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0})
      $display("FAIL reset state: got rdy=%b busy=%b done=%b err=%b rc=%0d j=%b k=%b want 1 0 0 0 0 0000 0000",
               ready0, busy0, done0, err0, rc0, j0, k0);
    else n_pass++;
    RESET = 1'b0;
    $display("txn reset: rdy=%b j=%b k=%b", ready0, j0, k0);
  endtask

  task automatic test_set_clear();
    int cyc, drv;
    load_bank(0, 4'b0000);
    sb.push_back('{is_err: 1'b0, retry: 2'd0, bank: 4'b1010, lat: 2, drives: 1});
    accept(0, 4'b1010);
    n_total++;
    if ({j0, k0, busy0, ready0} !== {4'b1010, 4'b0000, 1'b1, 1'b0})
      $display("FAIL set_clear drive: got j=%b k=%b busy=%b rdy=%b want 1010 0000 1 0", j0, k0, busy0, ready0);
    else n_pass++;
    wait_out(0, cyc, drv);
    check_result("set_clear", 0, cyc, drv);
  endtask

  task automatic test_equal_target();
    int cyc, drv;
    load_bank(0, 4'b1111);
    sb.push_back('{is_err: 1'b0, retry: 2'd0, bank: 4'b1111, lat: 2, drives: 0});
    accept(0, 4'b1111);
    n_total++;
    if ({j0, k0, busy0} !== {4'b0000, 4'b0000, 1'b1})
      $display("FAIL equal drive: got j=%b k=%b busy=%b want 0000 0000 1", j0, k0, busy0);
    else n_pass++;
    wait_out(0, cyc, drv);
    check_result("equal", 0, cyc, drv);
  endtask

  task automatic test_toggle();
    int cyc, drv;
    load_bank(1, 4'b0110);
    sb.push_back('{is_err: 1'b0, retry: 2'd0, bank: 4'b1100, lat: 2, drives: 1});
    accept(1, 4'b1100);
    n_total++;
    if ({j1, k1} !== {4'b1010, 4'b1010})
      $display("FAIL toggle drive: got j=%b k=%b want 1010 1010", j1, k1);
    else n_pass++;
    wait_out(1, cyc, drv);
    check_result("toggle", 1, cyc, drv);
  endtask

  task automatic test_retry_exhaust();
    int cyc, drv;
    load_bank(0, 4'b0000);
    stuck0 = 4'b0001;
    sb.push_back('{is_err: 1'b1, retry: 2'd2, bank: 4'b0001, lat: 6, drives: 3});
    accept(0, 4'b0001);
    wait_out(0, cyc, drv);
    check_result("retry_exhaust", 0, cyc, drv);
    stuck0 = 4'b0000;
    step();
    n_total++;
    if ({done0, err0, ready0} !== {1'b0, 1'b0, 1'b1})
      $display("FAIL retry_exhaust after: got done=%b err=%b rdy=%b want 0 0 1", done0, err0, ready0);
    else n_pass++;
  endtask

  task automatic test_reset_in_check();
    load_bank(0, 4'b0000);
    accept(0, 4'b1001);
    step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    n_total++;
    if ({ready0, busy0, done0, err0, j0, k0} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0})
      $display("FAIL reset_in_check: got rdy=%b busy=%b done=%b err=%b j=%b k=%b want 1 0 0 0 0000 0000",
               ready0, busy0, done0, err0, j0, k0);
    else n_pass++;
    step();
    n_total++;
    if ({done0, err0, busy0} !== 3'b000)
      $display("FAIL reset_in_check later: got done=%b err=%b busy=%b want 0 0 0", done0, err0, busy0);
    else n_pass++;
    $display("txn reset_in_check: rdy=%b done=%b err=%b", ready0, done0, err0);
  endtask

  task automatic test_back_to_back();
    int cyc, drv;
    load_bank(0, 4'b0000);
    sb.push_back('{is_err: 1'b0, retry: 2'd0, bank: 4'b0011, lat: 2, drives: 1});
    accept(0, 4'b0011);
    wait_out(0, cyc, drv);
    check_result("b2b_first", 0, cyc, drv);
    n_total++;
    if (ready0 !== 1'b1) $display("FAIL b2b ready in done cycle: got %b want 1", ready0);
    else n_pass++;
    sb.push_back('{is_err: 1'b0, retry: 2'd0, bank: 4'b0101, lat: 2, drives: 1});
    accept(0, 4'b0101);
    n_total++;
    if ({busy0, j0, k0} !== {1'b1, 4'b0100, 4'b0010})
      $display("FAIL b2b second drive: got busy=%b j=%b k=%b want 1 0100 0010", busy0, j0, k0);
    else n_pass++;
    wait_out(0, cyc, drv);
    check_result("b2b_second", 0, cyc, drv);
  endtask

  initial begin
    RESET      = 1'b1;
    in_target  = 4'b0;
    valid0     = 1'b0;
    valid1     = 1'b0;
    stuck0     = 4'b0;
    bank0_val  = 4'b0;
    bank1_val  = 4'b0;
    bank0_load = 1'b1;
    bank1_load = 1'b1;
    step();
    bank0_load = 1'b0;
    bank1_load = 1'b0;
    test_reset();
    test_set_clear();
    test_equal_target();
    test_toggle();
    test_retry_exhaust();
    test_reset_in_check();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
